// File: rtl/cmac_lbus_pkg.sv
// Shared LBUS segment geometry, AXIS beat layout and receive FSM state type
// for the CMAC LBUS-to-AXIS receive path.
package cmac_lbus_pkg;

    localparam int SEG_N     = 4;
    localparam int SEG_W     = 128;
    localparam int SEG_BYTES = 16;
    localparam int DATA_W    = SEG_N * SEG_W;
    localparam int STRB_W    = SEG_N * SEG_BYTES;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PKT  = 2'd1,
        ST_DROP = 2'd2
    } lbus_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic              last;
        logic              user;
    } axis_beat_t;

    localparam int BEAT_W = $bits(axis_beat_t);

endpackage

// File: rtl/axis_beat_fifo.sv
// First-word-fall-through beat FIFO with full / one-free / empty flags.
// Latency: a write at edge N is visible on the read side after edge N.
// Backpressure: writes while full are ignored; a same-cycle read frees the slot.
module axis_beat_fifo #(
    parameter int W     = 578,
    parameter int DEPTH = 16
) (
    input  logic         i_core_clk,
    input  logic         i_arst_n,
    input  logic         i_wr_vld,
    input  logic [W-1:0] i_wr_dat,
    output logic         o_rd_vld,
    input  logic         i_rd_rdy,
    output logic [W-1:0] o_rd_dat,
    output logic         o_full,
    output logic         o_one_free,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic [AW:0]  w_cnt;
    logic         w_wr;
    logic         w_rd;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_cnt      = r_wr_ptr - r_rd_ptr;
    assign o_empty    = (w_cnt == '0);
    assign o_full     = (w_cnt == (AW+1)'(DEPTH));
    assign o_one_free = (w_cnt == (AW+1)'(DEPTH - 1));
    assign o_rd_vld   = !o_empty;
    assign o_rd_dat   = r_mem[r_rd_ptr[AW-1:0]];
    assign w_rd       = o_rd_vld & i_rd_rdy;
    assign w_wr       = i_wr_vld & (!o_full | w_rd);

    always_ff @(posedge i_core_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_core_clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_dat;
    end

endmodule

// File: rtl/lbus_rx_to_axis.sv
// Converts 4-segment CMAC LBUS receive beats into 512-bit AXI-Stream packets.
// Latency: one cycle from LBUS beat to m_axis when the beat FIFO is empty.
// Backpressure: none toward LBUS; on FIFO overflow packets are truncated or dropped and counted.
module lbus_rx_to_axis
    import cmac_lbus_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 32
) (
    input  logic                user_clk,
    input  logic                user_rst_n,
    input  logic [DATA_W-1:0]   rx_data,
    input  logic [SEG_N-1:0]    rx_en,
    input  logic [SEG_N-1:0]    rx_sop,
    input  logic [SEG_N-1:0]    rx_eop,
    input  logic [SEG_N-1:0]    rx_err,
    input  logic [4*SEG_N-1:0]  rx_mty,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic [STRB_W-1:0]   m_axis_tstrb,
    output logic                m_axis_tlast,
    output logic                m_axis_tuser,
    output logic [CNT_W-1:0]    pkt_drop_cnt
);

    lbus_state_e      r_state;
    lbus_state_e      w_state_nxt;
    axis_beat_t       w_beat;
    axis_beat_t       w_rd_beat;
    logic             w_has_eop;
    logic [1:0]       w_eop_idx;
    logic             w_any_en;
    logic             w_rd;
    logic             w_fifo_full;
    logic             w_fifo_one_free;
    logic             w_fifo_empty;
    logic             w_no_room;
    logic             w_last_room;
    logic             w_wr;
    logic             w_trunc;
    logic             w_drop;
    logic [CNT_W-1:0] r_drop_cnt;
    logic             w_unused;

    assign w_unused    = ^{rx_sop[SEG_N-1:1], w_fifo_empty};
    assign w_any_en    = |rx_en;
    assign w_rd        = m_axis_tvalid & m_axis_tready;
    assign w_no_room   = w_fifo_full & ~w_rd;
    assign w_last_room = (w_fifo_one_free & ~w_rd) | (w_fifo_full & w_rd);

    // Scan downward so the lowest enabled eop segment wins.
    always_comb begin
        w_has_eop = 1'b0;
        w_eop_idx = '0;
        for (int s = SEG_N - 1; s >= 0; s--) begin
            if (rx_en[s] && rx_eop[s]) begin
                w_has_eop = 1'b1;
                w_eop_idx = 2'(s);
            end
        end
    end

    always_comb begin
        w_beat = '0;
        for (int s = 0; s < SEG_N; s++) begin
            for (int b = 0; b < SEG_BYTES; b++) begin
                w_beat.data[8*(SEG_BYTES*s + b) +: 8] = rx_data[SEG_W*s + SEG_W - 1 - 8*b -: 8];
            end
            if (rx_en[s] && !(w_has_eop && (2'(s) > w_eop_idx))) begin
                w_beat.strb[SEG_BYTES*s +: SEG_BYTES] = (w_has_eop && (2'(s) == w_eop_idx)) ?
                    ({SEG_BYTES{1'b1}} >> rx_mty[4*s +: 4]) : {SEG_BYTES{1'b1}};
            end
        end
        w_beat.last = w_has_eop | w_trunc;
        w_beat.user = w_trunc | (w_has_eop & rx_err[w_eop_idx]);
    end

    // Any packet beat taking the last free entry without eop closes the packet
    // as truncated, so a stored packet always ends with tlast.
    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_trunc     = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            ST_IDLE, ST_PKT: begin
                if (w_any_en && ((r_state == ST_PKT) || rx_sop[0])) begin
                    if (w_no_room) begin
                        w_drop      = 1'b1;
                        w_state_nxt = w_has_eop ? ST_IDLE : ST_DROP;
                    end else begin
                        w_wr = 1'b1;
                        if (w_has_eop) begin
                            w_state_nxt = ST_IDLE;
                        end else if (w_last_room) begin
                            w_trunc     = 1'b1;
                            w_drop      = 1'b1;
                            w_state_nxt = ST_DROP;
                        end else begin
                            w_state_nxt = ST_PKT;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (w_any_en && w_has_eop) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_state    <= ST_IDLE;
            r_drop_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_drop) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
    end

    axis_beat_fifo #(
        .W     (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_core_clk (user_clk),
        .i_arst_n   (user_rst_n),
        .i_wr_vld   (w_wr),
        .i_wr_dat   (w_beat),
        .o_rd_vld   (m_axis_tvalid),
        .i_rd_rdy   (m_axis_tready),
        .o_rd_dat   (w_rd_beat),
        .o_full     (w_fifo_full),
        .o_one_free (w_fifo_one_free),
        .o_empty    (w_fifo_empty)
    );

    assign m_axis_tdata = w_rd_beat.data;
    assign m_axis_tstrb = w_rd_beat.strb;
    assign m_axis_tlast = w_rd_beat.last;
    assign m_axis_tuser = w_rd_beat.user;
    assign pkt_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_lbus_rx_to_axis.sv
// Bench for lbus_rx_to_axis: vector table, directed multi-cycle corner cases,
// and random packet traffic against a queue-based reference model.
module tb_lbus_rx_to_axis;

    localparam int DEPTH = 16;

    logic         user_clk = 1'b0;
    logic         user_rst_n = 1'b0;
    logic [511:0] rx_data = '0;
    logic [3:0]   rx_en = '0;
    logic [3:0]   rx_sop = '0;
    logic [3:0]   rx_eop = '0;
    logic [3:0]   rx_err = '0;
    logic [15:0]  rx_mty = '0;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b1;
    logic [511:0] m_axis_tdata;
    logic [63:0]  m_axis_tstrb;
    logic         m_axis_tlast;
    logic         m_axis_tuser;
    logic [31:0]  pkt_drop_cnt;

    always #5 user_clk = ~user_clk;

    lbus_rx_to_axis #(.FIFO_DEPTH(DEPTH), .CNT_W(32)) dut (
        .user_clk      (user_clk),
        .user_rst_n    (user_rst_n),
        .rx_data       (rx_data),
        .rx_en         (rx_en),
        .rx_sop        (rx_sop),
        .rx_eop        (rx_eop),
        .rx_err        (rx_err),
        .rx_mty        (rx_mty),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .pkt_drop_cnt  (pkt_drop_cnt)
    );

    typedef struct packed {
        logic [511:0] data;
        logic [63:0]  strb;
        logic         last;
        logic         user;
    } ob_t;

    typedef struct {
        logic [3:0]   en, sop, eop, err;
        logic [15:0]  mty;
        logic [127:0] seg;
        logic         vld;
        logic [63:0]  strb;
        logic         last, user;
        logic [127:0] lo;
    } vec_t;

    ob_t         exp_q[$];
    bit          out_last[$];
    bit          out_user[$];
    int          checks = 0;
    int          errors = 0;
    int          mode = 0;        // 0 waiting for sop, 1 inside packet, 2 discarding
    int unsigned drop_ref = 0;
    int          rdy_pct = 100;
    int          pct_tab[4] = '{100, 60, 15, 0};
    vec_t        tv[7];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic int first_eop(input logic [3:0] en, input logic [3:0] eop);
        int e;
        e = -1;
        for (int i = 3; i >= 0; i--) if (en[i] && eop[i]) e = i;
        return e;
    endfunction

    function automatic ob_t mk_beat(input logic [3:0] en, input logic [3:0] eop, input logic [3:0] err,
                                    input logic [15:0] mty, input logic [511:0] d, input bit trunc);
        ob_t r;
        int  e, s, b;
        r = '0;
        e = first_eop(en, eop);
        for (int k = 0; k < 64; k++) begin
            s = k / 16;
            b = k % 16;
            r.data[8*k +: 8] = d[128*s + 127 - 8*b -: 8];
            r.strb[k] = en[s] && (e < 0 || s < e || (s == e && b < 16 - int'(mty[4*s +: 4])));
        end
        r.last = (e >= 0) || trunc;
        r.user = trunc || (e >= 0 && err[e]);
        return r;
    endfunction

    task automatic model_step();
        int e, free;
        bit trunc;
        if (rx_en == 4'd0) return;
        e = first_eop(rx_en, rx_eop);
        free = DEPTH - exp_q.size();
        if (mode == 2) begin
            if (e >= 0) mode = 0;
        end else if (mode == 1 || rx_sop[0]) begin
            if (free == 0) begin
                drop_ref++;
                mode = (e >= 0) ? 0 : 2;
            end else begin
                trunc = (e < 0) && (free == 1);
                exp_q.push_back(mk_beat(rx_en, rx_eop, rx_err, rx_mty, rx_data, trunc));
                if (e >= 0) mode = 0;
                else if (trunc) begin
                    drop_ref++;
                    mode = 2;
                end else mode = 1;
            end
        end
    endtask

    // Scoreboard: samples just after the falling edge, before the next rising edge acts.
    initial begin
        ob_t          e;
        logic [511:0] mask;
        forever begin
            @(negedge user_clk);
            #1;
            chk("tvalid", m_axis_tvalid, exp_q.size() != 0);
            chk("drop_cnt", pkt_drop_cnt, drop_ref);
            if (m_axis_tvalid && m_axis_tready) begin
                out_last.push_back(m_axis_tlast);
                out_user.push_back(m_axis_tuser);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got tvalid=1 tdata=%0h, expected no beat", m_axis_tdata);
                end else begin
                    e = exp_q.pop_front();
                    for (int k = 0; k < 64; k++) mask[8*k +: 8] = {8{e.strb[k]}};
                    chk("tstrb", m_axis_tstrb, e.strb);
                    chk("tdata", m_axis_tdata & mask, e.data & mask);
                    chk("tlast", m_axis_tlast, e.last);
                    chk("tuser", m_axis_tuser, e.user);
                end
            end
            if (user_rst_n) model_step();
        end
    end

    task automatic cyc(input logic [3:0] en, input logic [3:0] sop, input logic [3:0] eop,
                       input logic [3:0] err, input logic [15:0] mty, input logic [511:0] d);
        @(negedge user_clk);
        m_axis_tready = ($urandom_range(0, 99) < rdy_pct);
        rx_en  = en;
        rx_sop = sop;
        rx_eop = eop;
        rx_err = err;
        rx_mty = mty;
        rx_data = d;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(4'd0, 4'd0, 4'd0, 4'd0, 16'd0, '0);
    endtask

    task automatic do_reset();
        @(negedge user_clk);
        #3;
        user_rst_n = 1'b0;
        rx_en = '0;
        exp_q.delete();
        mode = 0;
        drop_ref = 0;
        #1;
        chk("rst_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_drop_cnt", pkt_drop_cnt, 32'd0);
        repeat (2) @(negedge user_clk);
        #3;
        user_rst_n = 1'b1;
    endtask

    task automatic rand_pkt(input int len);
        for (int i = 0; i < len; i++) begin
            int nseg, e;
            logic [3:0] en, eop, sop;
            nseg = $urandom_range(1, 4);
            en = 4'((1 << nseg) - 1);
            sop = {3'($urandom), (i == 0) ? 1'b1 : 1'b0};
            if (i == len - 1) begin
                e = $urandom_range(0, nseg - 1);
                eop = 4'(1 << e) | (4'($urandom) & ~4'((2 << e) - 1));
            end else begin
                eop = 4'($urandom) & ~en;
            end
            cyc(en, sop, eop, 4'($urandom), 16'($urandom), rand512());
        end
    endtask

    localparam logic [127:0] P0 = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] L0 = 128'hFFEEDDCCBBAA99887766554433221100;
    localparam logic [127:0] P1 = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] L1 = 128'h1032547698BADCFEEFCDAB8967452301;

    initial begin
        int n0;
        tv[0] = '{4'h1, 4'h1, 4'h1, 4'h1, 16'h0000, P0, 1'b1, 64'h0000_0000_0000_FFFF, 1'b1, 1'b1, L0};
        tv[1] = '{4'hF, 4'h1, 4'h8, 4'h7, 16'h0FFF, P1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, L1};
        tv[2] = '{4'h3, 4'h1, 4'h2, 4'h2, 16'h0040, P0, 1'b1, 64'h0000_0000_0FFF_FFFF, 1'b1, 1'b1, L0};
        tv[3] = '{4'hF, 4'h1, 4'h6, 4'hC, 16'h00F0, P1, 1'b1, 64'h0000_0000_0001_FFFF, 1'b1, 1'b0, L1};
        tv[4] = '{4'h7, 4'h1, 4'h4, 4'h0, 16'h0800, P0, 1'b1, 64'h0000_00FF_FFFF_FFFF, 1'b1, 1'b0, L0};
        tv[5] = '{4'h1, 4'hF, 4'hF, 4'hE, 16'hFFF0, P1, 1'b1, 64'h0000_0000_0000_FFFF, 1'b1, 1'b0, L1};
        tv[6] = '{4'hF, 4'hE, 4'h1, 4'h0, 16'h0000, P0, 1'b0, 64'h0, 1'b0, 1'b0, L0};

        do_reset();
        idle(1);
        #2;
        chk("reset_tvalid", m_axis_tvalid, 1'b0);
        chk("reset_drop_cnt", pkt_drop_cnt, 32'd0);

        for (int i = 0; i < 7; i++) begin
            cyc(tv[i].en, tv[i].sop, tv[i].eop, tv[i].err, tv[i].mty, {4{tv[i].seg}});
            idle(1);
            #2;
            chk($sformatf("tv%0d_tvalid", i), m_axis_tvalid, tv[i].vld);
            if (tv[i].vld) begin
                chk($sformatf("tv%0d_tstrb", i), m_axis_tstrb, tv[i].strb);
                chk($sformatf("tv%0d_tlast", i), m_axis_tlast, tv[i].last);
                chk($sformatf("tv%0d_tuser", i), m_axis_tuser, tv[i].user);
                chk($sformatf("tv%0d_tdata_lo", i), m_axis_tdata[127:0], tv[i].lo);
            end
        end

        for (int k = 0; k < 4; k++) begin
            case (k)
                0: cyc(4'hF, 4'h1, 4'h0, 4'h0, 16'h0, rand512());
                1: cyc(4'hF, 4'h0, 4'h0, 4'h0, 16'h0, rand512());
                2: cyc(4'h3, 4'h0, 4'h2, 4'h0, 16'h0040, rand512());
                default: idle(1);
            endcase
            #2;
            if (k > 0) begin
                chk($sformatf("p3_beat%0d_tvalid", k), m_axis_tvalid, 1'b1);
                chk($sformatf("p3_beat%0d_tlast", k), m_axis_tlast, k == 3);
                chk($sformatf("p3_beat%0d_tuser", k), m_axis_tuser, 1'b0);
            end
            if (k == 3) chk("p3_last_tstrb", m_axis_tstrb, 64'h0000_0000_0FFF_FFFF);
        end
        idle(3);

        do_reset();
        out_last.delete();
        out_user.delete();
        rdy_pct = 0;
        for (int i = 0; i < 20; i++)
            cyc(4'hF, (i == 0) ? 4'h1 : 4'h0, (i == 19) ? 4'h8 : 4'h0, 4'h0, 16'h0, rand512());
        idle(2);
        chk("ovf_drop_cnt", pkt_drop_cnt, 32'd1);
        rdy_pct = 100;
        idle(20);
        chk("ovf_beats_out", out_last.size(), 16);
        if (out_last.size() == 16) begin
            chk("ovf_beat16_tlast", out_last[15], 1'b1);
            chk("ovf_beat16_tuser", out_user[15], 1'b1);
            chk("ovf_beat15_tlast", out_last[14], 1'b0);
        end
        cyc(4'hF, 4'h1, 4'h0, 4'h0, 16'h0, rand512());
        cyc(4'h3, 4'h0, 4'h2, 4'h0, 16'h0, rand512());
        idle(4);
        chk("after_ovf_beats_out", out_last.size(), 18);
        if (out_last.size() == 18) begin
            chk("after_ovf_tlast", out_last[17], 1'b1);
            chk("after_ovf_tuser", out_user[17], 1'b0);
            chk("after_ovf_mid_tlast", out_last[16], 1'b0);
        end

        do_reset();
        rdy_pct = 100;
        n0 = out_last.size();
        cyc(4'hF, 4'h0, 4'h2, 4'h0, 16'h0, rand512());
        cyc(4'hF, 4'hE, 4'h0, 4'h0, 16'h0, rand512());
        cyc(4'h3, 4'h0, 4'h1, 4'h0, 16'h0, rand512());
        idle(2);
        chk("nosop_tvalid", m_axis_tvalid, 1'b0);
        chk("nosop_beats_out", out_last.size(), n0);
        rdy_pct = 0;
        cyc(4'hF, 4'h1, 4'h0, 4'h0, 16'h0, rand512());
        cyc(4'hF, 4'h0, 4'h0, 4'h0, 16'h0, rand512());
        cyc(4'hF, 4'h0, 4'h0, 4'h0, 16'h0, rand512());
        #2;
        chk("pre_rst_tvalid", m_axis_tvalid, 1'b1);
        do_reset();
        rdy_pct = 100;
        n0 = out_last.size();
        cyc(4'hF, 4'h0, 4'h0, 4'h0, 16'h0, rand512());
        cyc(4'hF, 4'h0, 4'h0, 4'h0, 16'h0, rand512());
        cyc(4'h3, 4'h0, 4'h2, 4'h0, 16'h0, rand512());
        idle(4);
        chk("post_rst_beats_out", out_last.size(), n0);
        chk("post_rst_tvalid", m_axis_tvalid, 1'b0);
        chk("post_rst_drop_cnt", pkt_drop_cnt, 32'd0);

        for (int p = 0; p < 300; p++) begin
            if (p % 25 == 0) rdy_pct = pct_tab[(p / 25) % 4];
            idle($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0)
                cyc(4'hF, {3'($urandom), 1'b0}, 4'($urandom), 4'($urandom), 16'($urandom), rand512());
            rand_pkt(($urandom_range(0, 9) == 0) ? $urandom_range(14, 22) : $urandom_range(1, 6));
        end

        rdy_pct = 100;
        idle(40);
        chk("drain_model_empty", exp_q.size(), 0);
        chk("drain_tvalid", m_axis_tvalid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lbus_rx_to_axis.md
LBUS_RX_TO_AXIS -- requirements
Module: lbus_rx_to_axis

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning beat FIFO depth in 512-bit entries (power of two, >=4).
REQ-002 SHALL have parameter CNT_W, default 32, meaning statistics counter width.
REQ-003 SHALL have port user_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port user_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx_data  in  512  segment s occupies bits [128s+127:128s].
REQ-006 SHALL have ports rx_en, rx_sop, rx_eop, rx_err  in  4 each  per-segment LBUS qualifiers.
REQ-007 SHALL have port rx_mty  in  16  segment s empty-byte count at bits [4s+3:4s].
REQ-008 SHALL have ports m_axis_tvalid out 1, m_axis_tready in 1, m_axis_tdata out 512, m_axis_tstrb out 64, m_axis_tlast out 1, m_axis_tuser out 1 (1 = errored or truncated packet).
REQ-009 SHALL have port pkt_drop_cnt  out  CNT_W  packets dropped or truncated for lack of FIFO space.

Function
REQ-010 A beat SHALL exist when any rx_en bit is 1; rx_en is contiguous from segment 0; no backpressure toward LBUS.
REQ-011 Packets SHALL start only at segment 0; rx_sop[3:1] SHALL be ignored.
REQ-012 Only the lowest-index segment with rx_en and rx_eop both 1 SHALL end the packet; higher segments in that beat SHALL be ignored.
REQ-013 Byte mapping: segment s bits [127-8b:120-8b] SHALL map to tdata byte 16s+b (LBUS big-endian to AXIS little-endian).
REQ-014 tstrb: enabled segments before the eop segment SHALL get 16 ones; eop segment SHALL get 16-mty low-order bits of its 16-bit group set; later or disabled segments SHALL get zeros.
REQ-015 tlast SHALL equal "beat contains eop"; tuser SHALL equal rx_err of the eop segment, or 1 on truncation (REQ-020).
REQ-016 FSM states IDLE, PKT, DROP; reset state IDLE.
REQ-017 IDLE: beat with rx_sop[0]=1 SHALL start a packet (PKT if no eop, stay IDLE if single-beat); beat without sop SHALL be discarded.
REQ-018 PKT: beat with eop SHALL return to IDLE; rx_sop[0]=1 in PKT is a CMAC violation with unspecified behaviour, and benches SHALL not drive it.
REQ-019 DROP: all beats SHALL be discarded; beat with eop SHALL go to IDLE.
REQ-020 In PKT, a non-eop beat arriving with exactly one free FIFO entry SHALL be written with tlast=1, tuser=1; pkt_drop_cnt SHALL increment; state SHALL become DROP.
REQ-021 A sop beat arriving with FIFO full SHALL be discarded, pkt_drop_cnt SHALL increment, and the state SHALL become DROP, or stay IDLE if the beat has eop.
REQ-022 Free-entry evaluation SHALL include a same-cycle read (tvalid and tready).
REQ-023 Latency: an accepted beat at edge N SHALL appear on m_axis at cycle N+1 when the FIFO was empty (first-word fall-through).
REQ-024 m_axis SHALL follow AXIS: data stable while tvalid and not tready; tvalid not dependent on tready.
REQ-025 pkt_drop_cnt SHALL wrap modulo 2^CNT_W.

Reset
REQ-026 On user_rst_n=0 the block SHALL immediately force: FSM IDLE, FIFO empty, m_axis_tvalid=0, pkt_drop_cnt=0; tdata/tstrb/tlast/tuser don't-care.
REQ-027 A packet in flight at reset SHALL be lost; post-reset beats before the next sop SHALL be discarded.

Structure
REQ-028 Package cmac_lbus_pkg SHALL hold: segment count 4, segment width 128, bytes per segment 16, FSM state enum.
REQ-029 The FIFO SHALL be sub-module axis_beat_fifo (FWFT, 578-bit entries: data+strb+last+user, full/one-free/empty flags).

Verification
REQ-030 3-beat packet (sop seg0, eop seg1 mty=4), tready=1 -> 3 beats out, last tstrb=64'h0000_0000_0FFF_FFFF, tlast only on beat 3, tuser=0.
REQ-031 Single beat, en=4'b0001, sop=eop=1, err=1, mty=0 -> one beat, tstrb=64'hFFFF, tlast=1, tuser=1.
REQ-032 rx_data seg0 = 128'h00112233_..._FF (byte 0 = 8'h00) -> tdata[7:0]=8'h00, tdata[127:120]=8'hFF.
REQ-033 tready=0, FIFO_DEPTH=16, 20-beat packet -> 16 beats stored, 16th tlast=1 tuser=1, pkt_drop_cnt=1, next complete packet passes intact.
REQ-034 Beats without sop after reset, then user_rst_n pulsed low mid-packet -> no output, tvalid=0 immediately, counter 0.
